// File: rtl/tkm_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tkm_serial_add_seq
//
// Bit-serial W-bit adder controller. One external half-adder cell
// (s = a ^ b, c = a & b) is time-shared across all operand bits. Each bit
// takes two passes through that cell to form a full-adder step:
//   PH0 : a[i] + b[i]      -> s1, c1
//   PH1 : s1   + carry     -> sum[i], carry' = c1 | c2
// The running carry is held in a flop between bits. An add takes 2W cycles
// of work plus one DONE cycle, and a new add can start straight from DONE.
//
// Ports
//   clk    : clock, all flops rising-edge
//   rst_n  : asynchronous active-low reset
//   start  : request, only looked at in IDLE or DONE
//   op_a   : operand A (W bits), captured on an accepted start
//   op_b   : operand B (W bits), captured on an accepted start
//   cin    : carry-in, captured on an accepted start
//   ha_a   : shared half-adder input A (decoded from state)
//   ha_b   : shared half-adder input B (decoded from state)
//   ha_s   : shared half-adder sum return (same cycle)
//   ha_c   : shared half-adder carry return (same cycle)
//   busy   : high while bits are being processed (PH0/PH1)
//   done   : one-cycle pulse; sum/cout are valid from this cycle
//   sum    : W-bit result, holds until a later add overwrites it
//   cout   : final carry-out, holds like sum
// ---------------------------------------------------------------------------
module tkm_serial_add_seq #(
  parameter int W     = 8,
  parameter int IDX_W = ($clog2(W) > 0) ? $clog2(W) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         ha_a,
  output logic         ha_b,
  input  logic         ha_s,
  input  logic         ha_c,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH0  = 2'd1,
    S_PH1  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               s1_q, s1_d;
  logic               c1_q, c1_d;
  logic               cout_q, cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s1_q    <= s1_d;
      c1_q    <= c1_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s1_d    = s1_q;
    c1_d    = c1_q;
    cout_d  = cout_q;
    ha_a    = 1'b0;
    ha_b    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Clearing sum here keeps bits above idx at zero while busy.
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_PH0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PH0: begin
        ha_a    = a_q[idx_q];
        ha_b    = b_q[idx_q];
        s1_d    = ha_s;
        c1_d    = ha_c;
        state_d = S_PH1;
      end
      S_PH1: begin
        // The two half-adder carries can never both be 1, so OR is exact.
        ha_a         = s1_q;
        ha_b         = carry_q;
        sum_d[idx_q] = ha_s;
        carry_d      = c1_q | ha_c;
        if (idx_q == LAST_IDX) begin
          cout_d  = c1_q | ha_c;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_PH0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_PH0) || (state_q == S_PH1);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
